// File: rtl/phosphor_trail_gen.sv
// phosphor_trail_gen: VGA pattern generator with emulated phosphor decay trail.
// Optional scanline dimming on odd lines when PTG_SCANLINE_EN is defined.
module phosphor_trail_gen #(
   parameter int COORD_BITS = 9,
   parameter int N_LAG      = 15,
   parameter int H_ACTIVE   = 512,
   parameter int V_ACTIVE   = 480,
   parameter int STEP_DIV   = 1,
   parameter int LVL3_MAX   = 2,
   parameter int LVL2_MAX   = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] hpos,
   input  logic [9:0] vpos,
   input  logic       display_on,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic       pause,
   input  logic [1:0] mode,
   input  logic [1:0] palette,
   output logic [1:0] R,
   output logic [1:0] G,
   output logic [1:0] B,
   output logic       hsync_out,
   output logic       vsync_out
);

   localparam int CB = COORD_BITS;
   localparam int AW = (N_LAG > 1) ? $clog2(N_LAG) : 1;
   localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [AW-1:0] L3 = AW'(LVL3_MAX);
   localparam logic [AW-1:0] L2 = AW'(LVL2_MAX);
   localparam logic [DW-1:0] DLAST = DW'(STEP_DIV - 1);

   logic [CB-1:0] frame_no, p, h, v;
   logic [DW-1:0] div_cnt;
   logic          vs_q, tick;
   logic [1:0]    mode_q, pal_q;
   logic          hit, hit1, act, act1, hs1, vs1, head;
   logic [AW-1:0] age, age1;
   logic [1:0]    lvl, r_n, g_n, b_n;
`ifdef PTG_SCANLINE_EN
   logic          odd1;
`endif

   assign h    = hpos[CB-1:0];
   assign v    = vpos[CB-1:0];
   assign tick = vsync_in & ~vs_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         vs_q     <= 1'b0;
         mode_q   <= 2'd0;
         pal_q    <= 2'd0;
         div_cnt  <= '0;
         frame_no <= '0;
      end else begin
         vs_q <= vsync_in;
         if (tick) begin
            mode_q <= mode;
            pal_q  <= palette;
            if (!pause) begin
               if (div_cnt == DLAST) begin
                  div_cnt  <= '0;
                  frame_no <= frame_no + CB'(1);
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
         end
      end
   end

   always_comb begin
      p = h;
      case (mode_q)
         2'd0:    p = h ^ v;
         2'd1:    p = h + v;
         2'd2:    p = h - v;
         default: p = h;
      endcase
   end

   // Scan from the oldest age down so the youngest match wins.
   always_comb begin
      hit = 1'b0;
      age = '0;
      for (int i = N_LAG - 1; i >= 0; i--) begin
         if (p == frame_no - CB'(i)) begin
            hit = 1'b1;
            age = AW'(i);
         end
      end
   end

   assign act = display_on
              & ({1'b0, vpos} < 11'(V_ACTIVE))
              & ({1'b0, hpos} < 11'(H_ACTIVE));

   always_ff @(posedge clk) begin
      if (reset) begin
         hit1 <= 1'b0;
         age1 <= '0;
         act1 <= 1'b0;
         hs1  <= 1'b0;
         vs1  <= 1'b0;
`ifdef PTG_SCANLINE_EN
         odd1 <= 1'b0;
`endif
      end else begin
         hit1 <= hit;
         age1 <= age;
         act1 <= act;
         hs1  <= hsync_in;
         vs1  <= vsync_in;
`ifdef PTG_SCANLINE_EN
         odd1 <= vpos[0];
`endif
      end
   end

   assign head = (age1 == '0);

   always_comb begin
      lvl = 2'd1;
      if (age1 <= L2) lvl = 2'd2;
      if (age1 <= L3) lvl = 2'd3;
`ifdef PTG_SCANLINE_EN
      if (odd1 && !head && lvl != 2'd0) lvl = lvl - 2'd1;
`endif
   end

   always_comb begin
      r_n = 2'd0;
      g_n = 2'd0;
      b_n = 2'd0;
      if (hit1 && act1) begin
         case (pal_q)
            2'd0: begin
               g_n = lvl;
               r_n = head ? lvl : 2'd0;
               b_n = head ? lvl : 2'd0;
            end
            2'd1: begin
               r_n = lvl;
               g_n = head ? lvl : {1'b0, lvl[1]};
            end
            2'd2: begin
               g_n = lvl;
               b_n = lvl;
               r_n = head ? lvl : 2'd0;
            end
            default: begin
               r_n = lvl;
               g_n = lvl;
               b_n = lvl;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         R         <= 2'd0;
         G         <= 2'd0;
         B         <= 2'd0;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
      end else begin
         R         <= r_n;
         G         <= g_n;
         B         <= b_n;
         hsync_out <= hs1;
         vsync_out <= vs1;
      end
   end

endmodule

// File: tb/tb_phosphor_trail_gen.sv
// tb_phosphor_trail_gen: directed and randomized checks against a frame-level
// reference model; define PTG_SCANLINE_EN to match a scanline-enabled build.
module tb_phosphor_trail_gen;

   localparam int SD = 2;
   localparam int NL = 15;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] hpos = '0;
   logic [9:0] vpos = '0;
   logic       display_on = 1'b0;
   logic       hsync_in = 1'b0;
   logic       vsync_in = 1'b0;
   logic       pause = 1'b0;
   logic [1:0] mode = '0;
   logic [1:0] palette = '0;
   logic [1:0] R, G, B;
   logic       hsync_out, vsync_out;

   int n_cmp = 0;
   int n_err = 0;

   // model state: unpaused tick count, latched selects, stage-1 result
   int uticks, m_vs, m_mode, m_pal;
   int s_on, s_age, s_odd, s_hs, s_vs;
   int exp_out;

   phosphor_trail_gen #(.STEP_DIV(SD)) dut (
      .clk        (clk),
      .reset      (reset),
      .hpos       (hpos),
      .vpos       (vpos),
      .display_on (display_on),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .pause      (pause),
      .mode       (mode),
      .palette    (palette),
      .R          (R),
      .G          (G),
      .B          (B),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int pat(int md, int h, int v);
      case (md)
         0:       return (h ^ v) & 511;
         1:       return (h + v) & 511;
         2:       return (h - v) & 511;
         default: return h & 511;
      endcase
   endfunction

   function automatic int rgb(int on, int age, int odd, int pal);
      int lv, r, g, b;
      bit hd;
      if (on == 0) return 0;
      hd = (age == 0);
      lv = (age <= 2) ? 3 : (age <= 6) ? 2 : 1;
`ifdef PTG_SCANLINE_EN
      if (odd != 0 && !hd && lv > 0) lv--;
`endif
      case (pal)
         0: begin g = lv; r = hd ? lv : 0; b = r; end
         1: begin r = lv; g = hd ? lv : lv / 2; b = 0; end
         2: begin g = lv; b = lv; r = hd ? lv : 0; end
         default: begin r = lv; g = lv; b = lv; end
      endcase
      return r * 16 + g * 4 + b;
   endfunction

   function automatic int cur_frame();
      return (uticks / SD) % 512;
   endfunction

   task automatic step();
      int p;
      @(posedge clk);
      if (reset) begin
         exp_out = 0;
         s_on = 0; s_age = 0; s_odd = 0; s_hs = 0; s_vs = 0;
         m_vs = 0; m_mode = 0; m_pal = 0; uticks = 0;
      end else begin
         exp_out = (rgb(s_on, s_age, s_odd, m_pal) << 2)
                 | (s_hs << 1) | s_vs;
         p     = pat(m_mode, int'(hpos) % 512, int'(vpos) % 512);
         s_age = (cur_frame() - p) & 511;
         s_on  = (s_age < NL && display_on && hpos < 512 && vpos < 480)
                 ? 1 : 0;
         s_odd = int'(vpos[0]);
         s_hs  = int'(hsync_in);
         s_vs  = int'(vsync_in);
         if (vsync_in && m_vs == 0) begin
            m_mode = int'(mode);
            m_pal  = int'(palette);
            if (!pause) uticks++;
         end
         m_vs = int'(vsync_in);
      end
      #1;
      check("out", {R, G, B, hsync_out, vsync_out}, exp_out);
   endtask

   task automatic vtick();
      vsync_in = 1'b1; step();
      vsync_in = 1'b0; step();
   endtask

   task automatic px(input int h, input int v, input bit de);
      hpos = 10'(h);
      vpos = 10'(v);
      display_on = de;
      step();
      step();
   endtask

   initial begin
      int a, t, h9, v9;

      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         vsync_in = ~vsync_in;
         hsync_in = ~hsync_in;
         step();
         check("rst", {R, G, B, hsync_out, vsync_out}, 0);
      end
      vsync_in = 1'b0;
      hsync_in = 1'b0;
      reset = 1'b0;
      hsync_in = 1'b1; step();
      check("hs_lat1", hsync_out, 0);
      hsync_in = 1'b0; step();
      check("hs_lat2", hsync_out, 1);
      step();

      mode = 2'd3; palette = 2'd3; pause = 1'b0;
      for (int i = 0; i < 6; i++) vtick();
      px(3, 0, 1);   check("step_head", {R, G, B}, 63);
      px(4, 0, 1);   check("step_none", {R, G, B}, 0);
      pause = 1'b1;
      for (int i = 0; i < 4; i++) vtick();
      pause = 1'b0;
      px(3, 0, 1);   check("pause_hold", {R, G, B}, 63);

      mode = 2'd0;
      for (int i = 0; i < 4; i++) vtick();
      px(3, 6, 1);   check("age0", {R, G, B}, 63);
      px(3, 7, 1);   check("age1", {R, G, B}, 63);
      px(5, 5, 1);   check("age5", {R, G, B}, 42);
      px(503, 0, 1); check("age14", {R, G, B}, 21);
      px(502, 0, 1); check("age15", {R, G, B}, 0);

      mode = 2'd1;
      px(2, 3, 1);   check("latch_old", {R, G, B}, 42);
      vtick();
      px(2, 3, 1);   check("latch_new", {R, G, B}, 63);

      px(512, 5, 1); check("blank_h", {R, G, B}, 0);
      px(37, 480, 1); check("blank_v", {R, G, B}, 0);
      px(2, 3, 0);   check("blank_de", {R, G, B}, 0);
      px(511, 6, 1); check("edge_h", {R, G, B}, 63);

      palette = 2'd1;
      vtick();
      px(0, 2, 1);   check("amber4", {R, G, B}, 36);

      palette = 2'd0;
      vtick();
`ifdef PTG_SCANLINE_EN
      px(1, 1, 1);   check("scan_dim", {R, G, B}, 4);
`else
      px(1, 1, 1);   check("scan_dim", {R, G, B}, 8);
`endif
      px(5, 1, 1);   check("scan_head", {R, G, B}, 63);

      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 7) == 0) vsync_in = ~vsync_in;
         hsync_in = 1'($urandom);
         if ($urandom_range(0, 63) == 0) pause = ~pause;
         if ($urandom_range(0, 31) == 0) mode = 2'($urandom);
         if ($urandom_range(0, 31) == 0) palette = 2'($urandom);
         display_on = ($urandom_range(0, 7) != 0);
         a  = int'($urandom_range(0, 20));
         t  = (cur_frame() - a) & 511;
         v9 = int'($urandom_range(0, 511));
         case (m_mode)
            0:       h9 = t ^ v9;
            1:       h9 = (t - v9) & 511;
            2:       h9 = (t + v9) & 511;
            default: h9 = t;
         endcase
         if ($urandom_range(0, 3) == 0) h9 = int'($urandom_range(0, 511));
         if ($urandom_range(0, 7) == 0) h9 += 512;
         if ($urandom_range(0, 7) == 0) v9 += 512;
         hpos = 10'(h9);
         vpos = 10'(v9);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
